multicycle_control: RTL and testbench

Finite-state controller that sequences the multicycle MIPS datapath. It drives write enables for the PC, the instruction register and the register file, plus mux selects and memory strobes, so the edge-triggered 32-bit datapath registers (IR, MDR, A, B, ALUOut) capture at the right cycles. It sits beside the datapath, decodes the IR opcode, and waits on a memory-ready handshake for every memory access. It also counts retired instructions for bring-up.

---
 rtl/multicycle_control.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : FSM sequencer for the multicycle MIPS datapath, with memory-ready
//            handshake, illegal-opcode pulse and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             memReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;

  state_t           r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  state_t           w_next;
  logic             w_op_illegal;
  logic             w_retire;

  // The branch decision is taken in the datapath by gating PCWriteCond with zero.
  logic             w_unused_zero;
  assign w_unused_zero = zero;

  // --------------------------------------------------------------------------
  // Next-state, retire and illegal-opcode decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next       = S_FETCH;
    w_op_illegal = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH:  w_next = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          c_OP_RTYPE:       w_next = S_EXEC;
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_BEQ:         w_next = S_BRANCH;
          c_OP_J:           w_next = S_JUMP;
          c_OP_ADDI:        w_next = S_ADDIEX;
          default: begin
            w_next       = S_FETCH;
            w_op_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_MEMWR: begin
        w_next   = memReady ? S_FETCH : S_MEMWR;
        w_retire = memReady;
      end
      S_EXEC:   w_next = S_RWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default:  w_next = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, illegal pulse and retired counter
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_op_illegal;
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control outputs, decoded from the registered state
  // --------------------------------------------------------------------------
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = memReady;
        PCWrite = memReady;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
    // Reset must never let a write or memory strobe escape, even mid-instruction.
    if (RST) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic        CLK;
  logic        RST;
  logic [5:0]  opcode;
  logic        zero;
  logic        memReady;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] retired;

  int          n_chk;
  int          n_fail;
  logic [31:0] exp_ret;

  multicycle_control #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .illegal(illegal), .retired(retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; memReady = 1'b1; opcode = 6'b000000; zero = 1'b0;
    cyc(); cyc();
    n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_chk++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    n_chk++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    n_chk++; if ({IRWrite, PCWrite, MemRead} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b expected 000", {IRWrite, PCWrite, MemRead}); end
    RST = 1'b0; exp_ret = 32'd0;
    #1;
    n_chk++; if ({IRWrite, PCWrite, MemRead, ALUSrcB} !== 5'b11101) begin n_fail++; $display("FAIL fetch_outputs: got %b expected 11101", {IRWrite, PCWrite, MemRead, ALUSrcB}); end
  endtask

  task automatic test_rtype();
    logic [3:0] exp_s [0:4];
    exp_s = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    opcode = 6'b000000; memReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (state !== exp_s[i]) begin n_fail++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
      n_chk++; if ({RegWrite, RegDst} !== {2{exp_s[i] == 4'd7}}) begin n_fail++; $display("FAIL rtype_regwrite[%0d]: got %b expected %b", i, {RegWrite, RegDst}, {2{exp_s[i] == 4'd7}}); end
      if (exp_s[i] == 4'd1) begin
        n_chk++; if (ALUSrcB !== 2'b11) begin n_fail++; $display("FAIL decode_alusrcb: got %b expected 11", ALUSrcB); end
      end
      if (exp_s[i] == 4'd6) begin
        n_chk++; if ({ALUSrcA, ALUSrcB, ALUOp} !== 5'b10010) begin n_fail++; $display("FAIL exec_alu: got %b expected 10010", {ALUSrcA, ALUSrcB, ALUOp}); end
      end
      if (i < 4) cyc();
    end
    exp_ret = exp_ret + 32'd1;
    n_chk++; if (retired !== exp_ret) begin n_fail++; $display("FAIL rtype_retired: got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_lw_stall();
    logic [3:0] exp_s [0:7];
    logic       mr    [0:7];
    exp_s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    mr    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      memReady = mr[i];
      #1;
      if (i == 7) exp_ret = exp_ret + 32'd1;
      n_chk++; if (state !== exp_s[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
      n_chk++; if (retired !== exp_ret) begin n_fail++; $display("FAIL lw_retired[%0d]: got %0d expected %0d", i, retired, exp_ret); end
      if (exp_s[i] == 4'd3) begin
        n_chk++; if ({MemRead, IorD, MemWrite} !== 3'b110) begin n_fail++; $display("FAIL lw_memrd[%0d]: got %b expected 110", i, {MemRead, IorD, MemWrite}); end
      end
      if (exp_s[i] == 4'd4) begin
        n_chk++; if ({RegWrite, MemtoReg, RegDst} !== 3'b110) begin n_fail++; $display("FAIL lw_memwb: got %b expected 110", {RegWrite, MemtoReg, RegDst}); end
      end
      if (i < 7) cyc();
    end
  endtask

  task automatic test_fetch_stall();
    opcode = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      memReady = 1'b0;
      #1;
      n_chk++; if ({state, IRWrite, PCWrite, MemRead} !== 7'b0000001) begin n_fail++; $display("FAIL fstall[%0d]: got %b expected 0000001", i, {state, IRWrite, PCWrite, MemRead}); end
      cyc();
    end
    memReady = 1'b1;
    #1;
    n_chk++; if ({state, IRWrite, PCWrite} !== 6'b000011) begin n_fail++; $display("FAIL fstall_pulse: got %b expected 000011", {state, IRWrite, PCWrite}); end
    cyc();
    n_chk++; if ({state, IRWrite, PCWrite} !== 6'b000100) begin n_fail++; $display("FAIL fstall_after: got %b expected 000100", {state, IRWrite, PCWrite}); end
    cyc(); cyc(); cyc();
    exp_ret = exp_ret + 32'd1;
    n_chk++; if ({state, retired} !== {4'd0, exp_ret}) begin n_fail++; $display("FAIL fstall_done: got %0d/%0d expected 0/%0d", state, retired, exp_ret); end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'b000100; zero = z[0]; memReady = 1'b1;
      #1;
      cyc();
      n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL beq%0d_decode: got %0d expected 1", z, state); end
      cyc();
      n_chk++; if (state !== 4'd8) begin n_fail++; $display("FAIL beq%0d_state: got %0d expected 8", z, state); end
      n_chk++; if ({PCWriteCond, PCSource, ALUOp, ALUSrcA, ALUSrcB, PCWrite} !== 9'b101011000) begin n_fail++; $display("FAIL beq%0d_ctrl: got %b expected 101011000", z, {PCWriteCond, PCSource, ALUOp, ALUSrcA, ALUSrcB, PCWrite}); end
      cyc();
      exp_ret = exp_ret + 32'd1;
      n_chk++; if ({state, retired} !== {4'd0, exp_ret}) begin n_fail++; $display("FAIL beq%0d_done: got %0d/%0d expected 0/%0d", z, state, retired, exp_ret); end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    opcode = 6'b000010; memReady = 1'b1;
    cyc(); cyc();
    n_chk++; if ({state, PCWrite, PCSource} !== 7'b1001110) begin n_fail++; $display("FAIL jump_ctrl: got %b expected 1001110", {state, PCWrite, PCSource}); end
    cyc();
    exp_ret = exp_ret + 32'd1;
    n_chk++; if ({state, retired} !== {4'd0, exp_ret}) begin n_fail++; $display("FAIL jump_done: got %0d/%0d expected 0/%0d", state, retired, exp_ret); end
  endtask

  task automatic test_addi();
    opcode = 6'b001000; memReady = 1'b1;
    cyc(); cyc();
    n_chk++; if ({state, ALUSrcA, ALUSrcB, ALUOp} !== 9'b101011000) begin n_fail++; $display("FAIL addi_ex: got %b expected 101011000", {state, ALUSrcA, ALUSrcB, ALUOp}); end
    cyc();
    n_chk++; if ({state, RegWrite, RegDst, MemtoReg} !== 7'b1011100) begin n_fail++; $display("FAIL addi_wb: got %b expected 1011100", {state, RegWrite, RegDst, MemtoReg}); end
    cyc();
    exp_ret = exp_ret + 32'd1;
    n_chk++; if ({state, retired} !== {4'd0, exp_ret}) begin n_fail++; $display("FAIL addi_done: got %0d/%0d expected 0/%0d", state, retired, exp_ret); end
  endtask

  task automatic test_sw();
    opcode = 6'b101011; memReady = 1'b1;
    cyc(); cyc();
    n_chk++; if ({state, ALUSrcA, ALUSrcB} !== 7'b0010110) begin n_fail++; $display("FAIL sw_memadr: got %b expected 0010110", {state, ALUSrcA, ALUSrcB}); end
    cyc();
    n_chk++; if ({state, MemWrite, IorD, MemRead} !== 7'b0101110) begin n_fail++; $display("FAIL sw_memwr: got %b expected 0101110", {state, MemWrite, IorD, MemRead}); end
    cyc();
    exp_ret = exp_ret + 32'd1;
    n_chk++; if ({state, retired} !== {4'd0, exp_ret}) begin n_fail++; $display("FAIL sw_done: got %0d/%0d expected 0/%0d", state, retired, exp_ret); end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; memReady = 1'b1;
    cyc();
    n_chk++; if ({state, RegWrite, MemWrite, illegal} !== 7'b0001000) begin n_fail++; $display("FAIL ill_decode: got %b expected 0001000", {state, RegWrite, MemWrite, illegal}); end
    memReady = 1'b0;
    cyc();
    n_chk++; if ({state, illegal, RegWrite, MemWrite} !== 7'b0000100) begin n_fail++; $display("FAIL ill_pulse: got %b expected 0000100", {state, illegal, RegWrite, MemWrite}); end
    n_chk++; if (retired !== exp_ret) begin n_fail++; $display("FAIL ill_retired: got %0d expected %0d", retired, exp_ret); end
    cyc();
    n_chk++; if ({state, illegal} !== 5'b00000) begin n_fail++; $display("FAIL ill_clear: got %b expected 00000", {state, illegal}); end
  endtask

  task automatic test_reset_mid();
    opcode = 6'b101011; memReady = 1'b1;
    cyc(); cyc();
    memReady = 1'b0;
    cyc(); cyc();
    n_chk++; if ({state, MemWrite} !== 5'b01011) begin n_fail++; $display("FAIL rmid_stall: got %b expected 01011", {state, MemWrite}); end
    RST = 1'b1;
    #1;
    n_chk++; if ({MemWrite, MemRead, RegWrite, PCWrite, IRWrite} !== 5'b00000) begin n_fail++; $display("FAIL rmid_strobes: got %b expected 00000", {MemWrite, MemRead, RegWrite, PCWrite, IRWrite}); end
    cyc();
    n_chk++; if ({state, retired} !== 36'd0) begin n_fail++; $display("FAIL rmid_after: got %0d/%0d expected 0/0", state, retired); end
    RST = 1'b0; exp_ret = 32'd0; opcode = 6'b000000; memReady = 1'b1;
    #1;
    n_chk++; if ({IRWrite, PCWrite, MemRead} !== 3'b111) begin n_fail++; $display("FAIL rmid_fetch: got %b expected 111", {IRWrite, PCWrite, MemRead}); end
    cyc();
    n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL rmid_decode: got %0d expected 1", state); end
    cyc(); cyc(); cyc();
    exp_ret = exp_ret + 32'd1;
    n_chk++; if ({state, retired} !== {4'd0, exp_ret}) begin n_fail++; $display("FAIL rmid_done: got %0d/%0d expected 0/%0d", state, retired, exp_ret); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; exp_ret = 32'd0;
    RST = 1'b1; opcode = 6'b0; zero = 1'b0; memReady = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_fetch_stall();
    test_beq();
    test_jump();
    test_addi();
    test_sw();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
